regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 70 +++++++
 tb/tb_regfile_wb_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin arbiter merging three write-back requesters into one registered register-file write port.
// Ports:
//   cclk          clock, rising edge
//   rstb          synchronous active-low reset
//   req_valid     per-requester write request (0 ALU, 1 LOAD, 2 MULDIV)
//   req_reg       5-bit destination index per requester
//   req_data      32-bit write data per requester
//   stall         blocks all grants in the current cycle
//   req_ready     combinational one-hot grant
//   rf_write      registered write enable
//   rf_write_reg  registered write index
//   rf_write_data registered write data
//   last_grant    most recently accepted requester, 3 when none since reset
//   wb_count      wrapping count of accepted requests
module regfile_wb_arbiter #(
    parameter bit DROP_R0 = 1'b1
) (
    input  logic        cclk,
    input  logic        rstb,
    input  logic [2:0]  req_valid,
    input  logic [14:0] req_reg,
    input  logic [95:0] req_data,
    input  logic        stall,
    output logic [2:0]  req_ready,
    output logic        rf_write,
    output logic [4:0]  rf_write_reg,
    output logic [31:0] rf_write_data,
    output logic [1:0]  last_grant,
    output logic [15:0] wb_count
);
    logic [1:0]  ptr;
    logic [1:0]  c1;
    logic [1:0]  c2;
    logic [1:0]  g;
    logic        fire;
    logic [4:0]  g_reg;
    logic [31:0] g_data;

    // c1/c2 are the second and third candidates after ptr, modulo 3
    always_comb begin
        c1        = (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
        c2        = (ptr == 2'd0) ? 2'd2 : ptr - 2'd1;
        g         = req_valid[ptr] ? ptr : req_valid[c1] ? c1 : c2;
        fire      = rstb && !stall && (|req_valid);
        req_ready = fire ? (3'b001 << g) : 3'b000;
        g_reg     = req_reg[5*g +: 5];
        g_data    = req_data[32*g +: 32];
    end

    always_ff @(posedge cclk) begin
        if (!rstb) begin
            ptr           <= 2'd0;
            rf_write      <= 1'b0;
            rf_write_reg  <= 5'd0;
            rf_write_data <= 32'd0;
            last_grant    <= 2'd3;
            wb_count      <= 16'd0;
        end else begin
            // a dropped r0 write still counts as a transfer, it just never reaches the file
            rf_write <= fire && !(DROP_R0 && g_reg == 5'd0);
            if (fire) begin
                ptr           <= (g == 2'd2) ? 2'd0 : g + 2'd1;
                rf_write_reg  <= g_reg;
                rf_write_data <= g_data;
                last_grant    <= g;
                wb_count      <= wb_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: vector table, corner sequences and randomized run against a reference model.
module tb_regfile_wb_arbiter;
    logic        cclk = 1'b0;
    logic        rstb;
    logic [2:0]  req_valid;
    logic [14:0] req_reg;
    logic [95:0] req_data;
    logic        stall;
    logic [2:0]  req_ready;
    logic        rf_write;
    logic [4:0]  rf_write_reg;
    logic [31:0] rf_write_data;
    logic [1:0]  last_grant;
    logic [15:0] wb_count;

    int checks = 0;
    int errors = 0;

    int          m_ptr;
    bit          m_write;
    logic [4:0]  m_reg;
    logic [31:0] m_data;
    int          m_last;
    logic [15:0] m_count;

    localparam logic [14:0] R567 = {5'd7, 5'd6, 5'd5};
    localparam logic [14:0] R705 = {5'd7, 5'd0, 5'd5};
    localparam logic [95:0] DABC = {32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};

    typedef struct {
        logic        rstb;
        logic [2:0]  valid;
        logic        stall;
        logic [14:0] regs;
        logic [2:0]  ready;
        logic        write;
        logic [4:0]  wreg;
        logic [1:0]  last;
        logic [15:0] count;
    } vec_t;

    vec_t tbl[16];

    regfile_wb_arbiter dut (
        .cclk(cclk),
        .rstb(rstb),
        .req_valid(req_valid),
        .req_reg(req_reg),
        .req_data(req_data),
        .stall(stall),
        .req_ready(req_ready),
        .rf_write(rf_write),
        .rf_write_reg(rf_write_reg),
        .rf_write_data(rf_write_data),
        .last_grant(last_grant),
        .wb_count(wb_count)
    );

    always #5 cclk = ~cclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // scan candidates ptr, ptr+1, ptr+2 (mod 3) for the first valid requester
    function automatic int model_grant();
        if (!rstb || stall) return -1;
        for (int k = 0; k < 3; k++)
            if (req_valid[(m_ptr + k) % 3]) return (m_ptr + k) % 3;
        return -1;
    endfunction

    task automatic model_update(input int g);
        if (!rstb) begin
            m_ptr = 0; m_write = 0; m_reg = 0; m_data = 0; m_last = 3; m_count = 0;
        end else begin
            m_write = 0;
            if (g >= 0) begin
                m_reg   = req_reg[g*5 +: 5];
                m_data  = req_data[g*32 +: 32];
                m_write = (m_reg != 5'd0);
                m_last  = g;
                m_count = m_count + 16'd1;
                m_ptr   = (g + 1) % 3;
            end
        end
    endtask

    task automatic step(input bit en, output logic [2:0] rdy);
        int g;
        #3;
        g   = model_grant();
        rdy = req_ready;
        if (en) chk("ready", 32'(req_ready), (g < 0) ? 32'd0 : 32'(1 << g));
        @(posedge cclk);
        model_update(g);
        #1;
        if (en) begin
            chk("rf_write", 32'(rf_write), 32'(m_write));
            chk("rf_write_reg", 32'(rf_write_reg), 32'(m_reg));
            chk("rf_write_data", rf_write_data, m_data);
            chk("last_grant", 32'(last_grant), 32'(m_last));
            chk("wb_count", 32'(wb_count), 32'(m_count));
        end
    endtask

    initial begin
        logic [2:0] rdy;
        m_ptr = 0; m_write = 0; m_reg = 0; m_data = 0; m_last = 3; m_count = 0;
        rstb = 0; req_valid = 0; req_reg = R567; req_data = DABC; stall = 0;

        tbl[0]  = '{1'b0, 3'b111, 1'b0, R567, 3'b000, 1'b0, 5'd0, 2'd3, 16'd0};
        tbl[1]  = '{1'b1, 3'b111, 1'b0, R567, 3'b001, 1'b1, 5'd5, 2'd0, 16'd1};
        tbl[2]  = '{1'b1, 3'b111, 1'b0, R567, 3'b010, 1'b1, 5'd6, 2'd1, 16'd2};
        tbl[3]  = '{1'b1, 3'b111, 1'b0, R567, 3'b100, 1'b1, 5'd7, 2'd2, 16'd3};
        tbl[4]  = '{1'b1, 3'b111, 1'b0, R567, 3'b001, 1'b1, 5'd5, 2'd0, 16'd4};
        tbl[5]  = '{1'b0, 3'b101, 1'b0, R567, 3'b000, 1'b0, 5'd0, 2'd3, 16'd0};
        tbl[6]  = '{1'b1, 3'b101, 1'b1, R567, 3'b000, 1'b0, 5'd0, 2'd3, 16'd0};
        tbl[7]  = '{1'b1, 3'b101, 1'b1, R567, 3'b000, 1'b0, 5'd0, 2'd3, 16'd0};
        tbl[8]  = '{1'b1, 3'b101, 1'b1, R567, 3'b000, 1'b0, 5'd0, 2'd3, 16'd0};
        tbl[9]  = '{1'b1, 3'b101, 1'b0, R567, 3'b001, 1'b1, 5'd5, 2'd0, 16'd1};
        tbl[10] = '{1'b1, 3'b101, 1'b0, R567, 3'b100, 1'b1, 5'd7, 2'd2, 16'd2};
        tbl[11] = '{1'b1, 3'b000, 1'b0, R567, 3'b000, 1'b0, 5'd7, 2'd2, 16'd2};
        tbl[12] = '{1'b1, 3'b010, 1'b0, R705, 3'b010, 1'b0, 5'd0, 2'd1, 16'd3};
        tbl[13] = '{1'b1, 3'b001, 1'b0, R705, 3'b001, 1'b1, 5'd5, 2'd0, 16'd4};
        tbl[14] = '{1'b1, 3'b100, 1'b0, R705, 3'b100, 1'b1, 5'd7, 2'd2, 16'd5};
        tbl[15] = '{1'b0, 3'b100, 1'b0, R705, 3'b000, 1'b0, 5'd0, 2'd3, 16'd0};

        for (int i = 0; i < 16; i++) begin
            rstb = tbl[i].rstb; req_valid = tbl[i].valid; stall = tbl[i].stall; req_reg = tbl[i].regs;
            step(1, rdy);
            chk($sformatf("tbl%0d_ready", i), 32'(rdy), 32'(tbl[i].ready));
            chk($sformatf("tbl%0d_write", i), 32'(rf_write), 32'(tbl[i].write));
            chk($sformatf("tbl%0d_reg", i), 32'(rf_write_reg), 32'(tbl[i].wreg));
            chk($sformatf("tbl%0d_last", i), 32'(last_grant), 32'(tbl[i].last));
            chk($sformatf("tbl%0d_count", i), 32'(wb_count), 32'(tbl[i].count));
        end

        // same destination from requesters 0 and 2: 0x11 then 0x22 on consecutive cycles
        rstb = 0; req_valid = 0; req_reg = {5'd9, 5'd0, 5'd9};
        req_data = {32'h22, 32'h0, 32'h11};
        step(1, rdy);
        rstb = 1; req_valid = 3'b101;
        step(1, rdy);
        chk("same_reg_ready0", 32'(rdy), 32'b001);
        chk("same_reg_data0", rf_write_data, 32'h11);
        chk("same_reg_we0", 32'(rf_write), 32'd1);
        req_valid = 3'b100;
        step(1, rdy);
        chk("same_reg_ready1", 32'(rdy), 32'b100);
        chk("same_reg_data1", rf_write_data, 32'h22);
        chk("same_reg_we1", 32'(rf_write), 32'd1);
        req_valid = 3'b000;
        step(1, rdy);
        chk("same_reg_idle", 32'(rf_write), 32'd0);

        // randomized run against the model
        req_data = DABC;
        for (int i = 0; i < 500; i++) begin
            rstb      = ($urandom_range(0, 29) != 0);
            stall     = ($urandom_range(0, 3) == 0);
            req_valid = 3'($urandom);
            req_reg   = 15'($urandom);
            req_data  = {$urandom, $urandom, $urandom};
            step(1, rdy);
        end

        // wb_count wraparound
        rstb = 0; stall = 0; req_valid = 3'b111; req_reg = R567;
        step(1, rdy);
        rstb = 1;
        for (int i = 0; i < 65535; i++) step(0, rdy);
        chk("count_ffff", 32'(wb_count), 32'h0000_FFFF);
        step(1, rdy);
        chk("count_wrap", 32'(wb_count), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
